// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle two's-complement subtractor, z = a - b - bin.
// One CHUNK-bit slice is subtracted per RUN cycle, LSB chunk first, with the
// borrow rippling between cycles through a register. Operands are latched when
// start is accepted, so the caller may change them immediately afterwards.
// WIDTH must be an integer multiple of CHUNK.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             bout,
   output logic             ovf
);

   localparam int N   = WIDTH / CHUNK;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int MSB = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] z_q;
   logic             bout_q;
   logic             ovf_q;

   // Chunk datapath: next slice difference and the result with that slice merged in.
   logic [31:0]      base_d;
   logic [CHUNK-1:0] a_chunk_d;
   logic [CHUNK-1:0] b_chunk_d;
   logic [CHUNK:0]   diff_d;
   logic [WIDTH-1:0] res_d;

   // Subtract the current chunk; the extra top bit of the difference is the borrow out.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      base_d    = 32'(cnt_q) * 32'(CHUNK);
      a_chunk_d = a_q[base_d +: CHUNK];
      b_chunk_d = b_q[base_d +: CHUNK];
      diff_d    = {1'b0, a_chunk_d} - {1'b0, b_chunk_d} - {{CHUNK{1'b0}}, borrow_q};
      res_d     = res_q;
      res_d[base_d +: CHUNK] = diff_d[CHUNK-1:0];
   end

   // Control FSM with registered busy/done and result registers updated only on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         z_q      <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            // DONE accepts start exactly like IDLE, giving back-to-back operation.
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
                  res_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               res_q    <= res_d;
               borrow_q <= diff_d[CHUNK];
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  z_q     <= res_d;
                  bout_q  <= diff_d[CHUNK];
                  ovf_q   <= (a_q[MSB] ^ b_q[MSB]) & (res_d[MSB] ^ a_q[MSB]);
                  state_q <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign z    = z_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=32, CHUNK=8.
// Expected results are pushed to a scoreboard queue when an operation is
// accepted and popped when the done pulse is observed.
module tb_serial_subtractor;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   typedef struct packed {
      logic [WIDTH-1:0] z;
      logic             bout;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] z;
   logic             bout;
   logic             ovf;

   int               checks = 0;
   int               errors = 0;
   exp_t             sb[$];
   logic [WIDTH-1:0] last_z = '0;

   serial_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .z     (z),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
      exp_t        r;
      logic [WIDTH:0] t;
      t      = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(c);
      r.z    = t[WIDTH-1:0];
      r.bout = t[WIDTH];
      r.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (r.z[WIDTH-1] != x[WIDTH-1]);
      return r;
   endfunction

   // Drive start for one edge (the accept edge), push the expectation, then scramble operands.
   task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c, input exp_t e);
      a     = x;
      b     = y;
      bin   = c;
      start = 1'b1;
      sb.push_back(e);
      step();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      bin   = 1'($urandom_range(0, 1));
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_done", 32'(done), 32'd0);
   endtask

   // Run the remaining N edges to DONE; optionally re-pulse start in RUN to show it is ignored.
   task automatic finish_op(input bit glitch);
      exp_t e;
      for (int i = 1; i < N; i++) begin
         if (glitch && i == 1) begin
            start = 1'b1;
            a     = 32'd1;
            b     = 32'd7;
            bin   = 1'b0;
         end
         step();
         start = 1'b0;
         check("run_busy", 32'(busy), 32'd1);
         check("run_done", 32'(done), 32'd0);
         check("run_z_hold", z, last_z);
      end
      step();
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         check("z", z, e.z);
         check("bout", 32'(bout), 32'(e.bout));
         check("ovf", 32'(ovf), 32'(e.ovf));
         last_z = e.z;
      end
   endtask

   // One idle edge after DONE: done must drop and outputs must hold.
   task automatic idle_after_done();
      step();
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_z_hold", z, last_z);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_z", z, 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      reset = 1'b0;
      step();
      check("post_rst_busy", 32'(busy), 32'd0);

      // Basic: 5 - 3.
      start_op(32'd5, 32'd3, 1'b0, '{z: 32'h0000_0002, bout: 1'b0, ovf: 1'b0});
      finish_op(1'b0);
      idle_after_done();

      // Unsigned underflow: 0 - 1.
      start_op(32'd0, 32'd1, 1'b0, '{z: 32'hFFFF_FFFF, bout: 1'b1, ovf: 1'b0});
      finish_op(1'b0);
      idle_after_done();

      // Signed overflow: 0x80000000 - 1.
      start_op(32'h8000_0000, 32'd1, 1'b0, '{z: 32'h7FFF_FFFF, bout: 1'b0, ovf: 1'b1});
      finish_op(1'b0);
      idle_after_done();

      // Borrow ripples through every chunk: x - x - 1.
      start_op(32'h1234_5678, 32'h1234_5678, 1'b1, '{z: 32'hFFFF_FFFF, bout: 1'b1, ovf: 1'b0});
      finish_op(1'b0);
      idle_after_done();

      // Start re-pulsed during RUN with 1-7 is ignored: result stays 9-4.
      start_op(32'd9, 32'd4, 1'b0, '{z: 32'h0000_0005, bout: 1'b0, ovf: 1'b0});
      finish_op(1'b1);
      idle_after_done();

      // Back-to-back: start asserted in the DONE cycle is accepted with no IDLE cycle.
      start_op(32'd100, 32'd1, 1'b0, '{z: 32'd99, bout: 1'b0, ovf: 1'b0});
      finish_op(1'b0);
      start_op(32'd7, 32'd7, 1'b0, '{z: 32'd0, bout: 1'b0, ovf: 1'b0});
      finish_op(1'b0);
      idle_after_done();

      // Reset asserted in the 2nd RUN cycle aborts the operation.
      start_op(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, '{z: 32'hDEAD_BEEE, bout: 1'b0, ovf: 1'b0});
      void'(sb.pop_back());
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_z", z, 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      last_z = '0;
      for (int i = 0; i < N + 2; i++) begin
         step();
         check("abort_no_done", 32'(done), 32'd0);
      end

      // Reset and start on the same edge: reset wins.
      reset = 1'b1;
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      check("rst_vs_start_busy", 32'(busy), 32'd0);
      step();
      check("rst_vs_start_idle", 32'(busy), 32'd0);

      // Normal operation after reset.
      start_op(32'd1000, 32'd1, 1'b1, '{z: 32'd998, bout: 1'b0, ovf: 1'b0});
      finish_op(1'b0);
      idle_after_done();

      // Random operations with a random 0/1 idle gap (gap 0 exercises back-to-back).
      for (int k = 0; k < 1000; k++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         logic             rc;
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         if (k % 8 == 0) rb = ra;
         start_op(ra, rb, rc, model(ra, rb, rc));
         finish_op(1'b0);
         if ($urandom_range(0, 1) == 1) idle_after_done();
      end
      idle_after_done();

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
